// File: rtl/load_store_unit_if.sv
// Bundles the request, data-memory and write-back signals of the load/store unit.
// master is the unit side; slave is the execute stage, memory and write-back side.
interface load_store_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_rd;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
           mem_rdata, wb_ready,
    output req_ready, mem_read, mem_write, mem_addr, mem_wdata,
           wb_valid, wb_rd, wb_data, busy
  );

  modport slave (
    output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
           mem_rdata, wb_ready,
    input  req_ready, mem_read, mem_write, mem_addr, mem_wdata,
           wb_valid, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: takes one request, computes base+offset,
// drives DataMemory for one (store) or MEM_LAT (load) cycles, then returns load data.
module load_store_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        r_state;
  logic              r_is_store;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [2:0]        r_cnt;
  logic              w_idle;

  assign w_idle = (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_is_store <= bus.req_is_store;
          r_addr     <= bus.req_base + bus.req_offset;  // carry out discarded
          r_wdata    <= bus.req_wdata;
          r_rd       <= bus.req_rd;
          r_state    <= ACCESS;
        end
        ACCESS: begin
          if (r_is_store) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= 3'(MEM_LAT - 1);
            if (MEM_LAT == 1) begin
              r_wb_data <= bus.mem_rdata;
              r_state   <= RESP;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 3'd1) begin
            r_wb_data <= bus.mem_rdata;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: if (bus.wb_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for an edge.
  assign bus.req_ready = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.mem_write = (r_state == ACCESS) && r_is_store;
  assign bus.mem_read  = ((r_state == ACCESS) && !r_is_store) || (r_state == WAIT);
  assign bus.mem_addr  = w_idle ? '0 : r_addr;
  assign bus.mem_wdata = w_idle ? '0 : r_wdata;
  assign bus.wb_valid  = (r_state == RESP);
  assign bus.wb_rd     = r_rd;
  assign bus.wb_data   = r_wb_data;
endmodule
